// File: rtl/ms_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clk, start/busy/done handshake.
// Optional build macro BCD_BLANK_EN adds a registered leading-zero blanking output.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start; bcd_out holds the last result
//   S_SHIFT | converting, one bit of the captured input per clock
module ms_bcd_converter #(
  parameter int IN_W   = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic               unused_adj_top;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               zero_above;
`endif

  // Add-3 correction, every digit evaluated in parallel from the pre-shift scratch value.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Pre-shift value is below 10^DIGITS/2, so the top digit never exceeds 4 and its MSB is always 0.
  assign unused_adj_top = adj[BCD_W-1];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
`ifdef BCD_BLANK_EN
    blank_d    = blank_q;
    zero_above = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(IN_W);
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], shift_q[IN_W-1]};
        shift_d   = {shift_q[IN_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          bcd_d   = scratch_d;
          done_d  = 1'b1;
`ifdef BCD_BLANK_EN
          // Walk from the most significant digit down; units digit is never blanked.
          for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (scratch_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
          end
          blank_d[0] = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

`ifdef BCD_BLANK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

  assign busy    = (state_q == S_SHIFT);
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_ms_bcd_converter.sv
// Directed testbench for ms_bcd_converter: vector table plus hand-written multi-cycle sequences.
// Build with BCD_BLANK_EN defined to also check the blanking output.
module tb_ms_bcd_converter;

  localparam int IN_W   = 20;
  localparam int DIGITS = 7;

  logic                clk = 1'b0;
  logic                reset;
  logic [IN_W-1:0]     bin_in;
  logic                start;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]   blank;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ms_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .bin_in  (bin_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
`ifdef BCD_BLANK_EN
    ,
    .blank   (blank)
`endif
  );

  typedef struct {
    logic [IN_W-1:0]     bin;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blk;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full conversion: start edge, IN_W busy cycles with stable bcd_out, then the done cycle.
  task automatic run_conv(input logic [IN_W-1:0] b, input logic [4*DIGITS-1:0] eb,
                          input logic [DIGITS-1:0] ek, input logic [IN_W-1:0] late_bin,
                          input string name);
    logic [4*DIGITS-1:0] prev;
    logic win_ok;
    prev   = bcd_out;
    win_ok = 1'b1;
    bin_in = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = late_bin;
    for (int k = 0; k < IN_W; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || bcd_out !== prev) win_ok = 1'b0;
      tick();
    end
    check({name, "_window"}, {31'd0, win_ok}, 32'd1);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({name, "_bcd"}, {4'd0, bcd_out}, {4'd0, eb});
`ifdef BCD_BLANK_EN
    check({name, "_blank"}, {25'd0, blank}, {25'd0, ek});
`else
    if (ek === 'x) $display("note: unknown blank expectation");
`endif
    tick();
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dones;
    int dcyc;
    int d1;
    int d2;
    logic stable_ok;

    vecs[0]  = '{20'd0,       28'h0000000, 7'b1111110};
    vecs[1]  = '{20'hFFFFF,   28'h1048575, 7'b0000000};
    vecs[2]  = '{20'd999,     28'h0000999, 7'b1111000};
    vecs[3]  = '{20'd1,       28'h0000001, 7'b1111110};
    vecs[4]  = '{20'd9,       28'h0000009, 7'b1111110};
    vecs[5]  = '{20'd10,      28'h0000010, 7'b1111100};
    vecs[6]  = '{20'd1000,    28'h0001000, 7'b1110000};
    vecs[7]  = '{20'd65535,   28'h0065535, 7'b1100000};
    vecs[8]  = '{20'd100000,  28'h0100000, 7'b1000000};
    vecs[9]  = '{20'd524288,  28'h0524288, 7'b1000000};
    vecs[10] = '{20'd999999,  28'h0999999, 7'b1000000};
    vecs[11] = '{20'd1000000, 28'h1000000, 7'b0000000};

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {4'd0, bcd_out}, 32'd0);
`ifdef BCD_BLANK_EN
    check("reset_blank", {25'd0, blank}, 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].blk, IN_W'($urandom), $sformatf("vec%0d", i));
    end

    // Input changed mid-conversion must not affect the result.
    run_conv(20'd999, 28'h0000999, 7'b1111000, 20'd5, "late_bin");

    // Second start while busy is ignored.
    bin_in = 20'd123456;
    start  = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    dcyc  = -1;
    for (int c = 1; c <= 25; c++) begin
      if (c == 5) begin
        start  = 1'b1;
        bin_in = 20'd7;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        dcyc = c;
      end
    end
    check("ignore_done_count", dones, 1);
    check("ignore_done_cycle", dcyc, 20);
    check("ignore_bcd", {4'd0, bcd_out}, 32'h0123456);
    check("ignore_busy", {31'd0, busy}, 32'd0);

    // Reset mid-conversion aborts with no done pulse.
    bin_in = 20'd500000;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {4'd0, bcd_out}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
`ifdef BCD_BLANK_EN
    check("abort_blank", {25'd0, blank}, 32'd0);
`endif
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    run_conv(20'd42, 28'h0000042, 7'b1111100, 20'd3, "after_abort");

    // Start held high: conversions back to back every IN_W+1 cycles.
    bin_in = 20'd10;
    start  = 1'b1;
    tick();
    bin_in    = 20'd20;
    dones     = 0;
    d1        = -1;
    d2        = -1;
    stable_ok = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      tick();
      if (done === 1'b1) begin
        dones++;
        if (d1 < 0) begin
          d1 = c;
          check("held_first_bcd", {4'd0, bcd_out}, 32'h0000010);
        end else begin
          d2 = c;
          check("held_second_bcd", {4'd0, bcd_out}, 32'h0000020);
        end
      end else if (c > 20 && bcd_out !== 28'h0000010) begin
        stable_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("held_done_count", dones, 2);
    check("held_first_cycle", d1, 20);
    check("held_second_cycle", d2, 41);
    check("held_stable", {31'd0, stable_ok}, 32'd1);
`ifdef BCD_BLANK_EN
    check("held_blank", {25'd0, blank}, {25'd0, 7'b1111100});
`endif
    tick();
    check("held_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
